// File: rtl/int_ack_sequencer_pkg.sv
// Shared types and constants for the interrupt acknowledge sequencer.
package int_seq_pkg;
   typedef enum logic [1:0] {IDLE, ACK, VECT, SERVICE} int_seq_state_t;
   localparam int unsigned INTV_W     = 3;
   localparam int unsigned NUM_LEVELS = 8;
endpackage

// File: rtl/int_ack_sequencer_if.sv
// Core/controller-side signal bundle of the interrupt acknowledge sequencer.
interface int_ack_sequencer_if #(
   parameter int unsigned ADDR_W = 16
);
   logic                            INT;
   logic                            INTACK;
   logic [int_seq_pkg::INTV_W-1:0]  INTV;
   logic                            INSTR_BOUNDARY;
   logic [ADDR_W-1:0]               PC_IN;
   logic                            IE_SET;
   logic                            IE_CLR;
   logic                            RETI;
   logic                            STALL;
   logic                            TAKE;
   logic [ADDR_W-1:0]               VECTOR_ADDR;
   logic                            RESTORE;
   logic [ADDR_W-1:0]               SAVED_PC;
   logic                            IN_SERVICE;
   logic                            IE;

   modport slave (
      input  INT, INTV, INSTR_BOUNDARY, PC_IN, IE_SET, IE_CLR, RETI,
      output INTACK, STALL, TAKE, VECTOR_ADDR, RESTORE, SAVED_PC, IN_SERVICE, IE
   );

   modport master (
      output INT, INTV, INSTR_BOUNDARY, PC_IN, IE_SET, IE_CLR, RETI,
      input  INTACK, STALL, TAKE, VECTOR_ADDR, RESTORE, SAVED_PC, IN_SERVICE, IE
   );
endinterface

// File: rtl/int_ack_timer.sv
// Loadable down-counter timing the INTACK hold window; done marks the last cycle.
module int_ack_timer #(
   parameter int unsigned HOLD = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_load,
   output logic o_done
);
   localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD) : 1;

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= CW'(HOLD - 1);
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_done = (r_cnt == '0);
endmodule

// File: rtl/int_ack_sequencer.sv
// CPU-side interrupt handshake: sample INT at a boundary, hold INTACK, latch INTV,
// redirect to the vector, and restore the saved PC on RETI.
module int_ack_sequencer
   import int_seq_pkg::*;
#(
   parameter int unsigned       ADDR_W          = 16,
   parameter logic [ADDR_W-1:0] VEC_BASE        = 16'hFF00,
   parameter int unsigned       VEC_STRIDE_LOG2 = 2,
   parameter int unsigned       ACK_HOLD        = 2
) (
   input  logic                CLK,
   input  logic                RST,
   int_ack_sequencer_if.slave  bus
);
   int_seq_state_t    r_state,    w_state;
   logic              r_intack,   w_intack;
   logic              r_stall,    w_stall;
   logic              r_take,     w_take;
   logic              r_restore,  w_restore;
   logic              r_insvc,    w_insvc;
   logic              r_ie,       w_ie;
   logic [ADDR_W-1:0] r_saved_pc, w_saved_pc;
   logic [ADDR_W-1:0] r_vaddr,    w_vaddr;
   logic [INTV_W-1:0] r_vec_q,    w_vec_q;
   logic              w_tmr_load;
   logic              w_tmr_done;

   int_ack_timer #(.HOLD(ACK_HOLD)) u_timer (
      .i_clk  (CLK),
      .i_rst  (RST),
      .i_load (w_tmr_load),
      .o_done (w_tmr_done)
   );

   always_comb begin
      w_state    = r_state;
      w_intack   = r_intack;
      w_stall    = r_stall;
      w_take     = 1'b0;
      w_restore  = 1'b0;
      w_insvc    = r_insvc;
      w_ie       = r_ie;
      w_saved_pc = r_saved_pc;
      w_vaddr    = r_vaddr;
      w_vec_q    = r_vec_q;
      w_tmr_load = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.INT && r_ie && bus.INSTR_BOUNDARY) begin
               w_state    = ACK;
               w_saved_pc = bus.PC_IN;
               w_ie       = 1'b0;
               w_stall    = 1'b1;
               w_intack   = 1'b1;
               w_tmr_load = 1'b1;
            end else if (bus.IE_CLR) begin
               w_ie = 1'b0;
            end else if (bus.IE_SET) begin
               w_ie = 1'b1;
            end
         end
         ACK: begin
            if (w_tmr_done) begin
               // vector address is formed from INTV on the same edge it is latched
               w_vec_q  = bus.INTV;
               w_vaddr  = VEC_BASE + (ADDR_W'(w_vec_q) << VEC_STRIDE_LOG2);
               w_intack = 1'b0;
               w_take   = 1'b1;
               w_state  = VECT;
            end
         end
         VECT: begin
            w_stall = 1'b0;
            w_insvc = 1'b1;
            w_state = SERVICE;
         end
         SERVICE: begin
            if (bus.RETI) begin
               w_restore = 1'b1;
               w_ie      = 1'b1;
               w_insvc   = 1'b0;
               w_state   = IDLE;
            end
         end
         default: w_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= IDLE;
         r_intack   <= 1'b0;
         r_stall    <= 1'b0;
         r_take     <= 1'b0;
         r_restore  <= 1'b0;
         r_insvc    <= 1'b0;
         r_ie       <= 1'b0;
         r_saved_pc <= '0;
         r_vaddr    <= '0;
         r_vec_q    <= '0;
      end else begin
         r_state    <= w_state;
         r_intack   <= w_intack;
         r_stall    <= w_stall;
         r_take     <= w_take;
         r_restore  <= w_restore;
         r_insvc    <= w_insvc;
         r_ie       <= w_ie;
         r_saved_pc <= w_saved_pc;
         r_vaddr    <= w_vaddr;
         r_vec_q    <= w_vec_q;
      end
   end

   assign bus.INTACK      = r_intack;
   assign bus.STALL       = r_stall;
   assign bus.TAKE        = r_take;
   assign bus.RESTORE     = r_restore;
   assign bus.IN_SERVICE  = r_insvc;
   assign bus.IE          = r_ie;
   assign bus.SAVED_PC    = r_saved_pc;
   assign bus.VECTOR_ADDR = r_vaddr;
endmodule

// File: tb/tb_int_ack_sequencer.sv
// Bench: two sequencers (default and wrapping vector base) against a behavioural model.
module tb_int_ack_sequencer;
   localparam int unsigned H      = 2;
   localparam int unsigned BASE_A = 32'hFF00;
   localparam int unsigned SH_A   = 2;
   localparam int unsigned BASE_B = 32'hFFF0;
   localparam int unsigned SH_B   = 3;

   logic        CLK = 1'b0;
   logic        t_rst = 1'b1, t_int = 1'b0, t_bnd = 1'b0, t_set = 1'b0, t_clr = 1'b0, t_reti = 1'b0;
   logic [2:0]  t_intv = 3'd0;
   logic [15:0] t_pc = 16'h0;

   int cmp_cnt = 0;
   int err_cnt = 0;

   always #5 CLK = ~CLK;

   int_ack_sequencer_if #(.ADDR_W(16)) bus_a ();
   int_ack_sequencer_if #(.ADDR_W(16)) bus_b ();

   assign bus_a.INT = t_int;            assign bus_b.INT = t_int;
   assign bus_a.INTV = t_intv;          assign bus_b.INTV = t_intv;
   assign bus_a.INSTR_BOUNDARY = t_bnd; assign bus_b.INSTR_BOUNDARY = t_bnd;
   assign bus_a.PC_IN = t_pc;           assign bus_b.PC_IN = t_pc;
   assign bus_a.IE_SET = t_set;         assign bus_b.IE_SET = t_set;
   assign bus_a.IE_CLR = t_clr;         assign bus_b.IE_CLR = t_clr;
   assign bus_a.RETI = t_reti;          assign bus_b.RETI = t_reti;

   int_ack_sequencer #(.ADDR_W(16), .VEC_BASE(16'hFF00), .VEC_STRIDE_LOG2(2), .ACK_HOLD(2)) u_a (
      .CLK(CLK), .RST(t_rst), .bus(bus_a));
   int_ack_sequencer #(.ADDR_W(16), .VEC_BASE(16'hFFF0), .VEC_STRIDE_LOG2(3), .ACK_HOLD(2)) u_b (
      .CLK(CLK), .RST(t_rst), .bus(bus_b));

   // Behavioural model: handshake is a cycle count since entry, not a state machine.
   bit          m_active, m_svc, m_ie, m_restore;
   int unsigned m_t;
   int unsigned m_saved, m_va, m_vb;

   task automatic model_update();
      if (t_rst) begin
         m_active = 0; m_svc = 0; m_ie = 0; m_restore = 0; m_t = 0;
         m_saved = 0; m_va = 0; m_vb = 0;
      end else begin
         m_restore = 0;
         if (m_svc) begin
            if (t_reti) begin m_restore = 1; m_ie = 1; m_svc = 0; end
         end else if (m_active) begin
            if (m_t == H) begin
               m_va = (BASE_A + t_intv * (1 << SH_A)) % 65536;
               m_vb = (BASE_B + t_intv * (1 << SH_B)) % 65536;
               m_t  = H + 1;
            end else if (m_t == H + 1) begin
               m_active = 0; m_svc = 1;
            end else begin
               m_t++;
            end
         end else begin
            if (t_int && m_ie && t_bnd) begin
               m_saved = t_pc; m_ie = 0; m_active = 1; m_t = 1;
            end else if (t_clr) m_ie = 0;
            else if (t_set) m_ie = 1;
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      logic [5:0] exp_f, act_f;
      exp_f = {m_active && (m_t <= H), m_active && (m_t == H + 1), m_active, m_restore, m_svc, m_ie};
      act_f = {bus_a.INTACK, bus_a.TAKE, bus_a.STALL, bus_a.RESTORE, bus_a.IN_SERVICE, bus_a.IE};
      chk("model_flags_a", 32'(act_f), 32'(exp_f));
      act_f = {bus_b.INTACK, bus_b.TAKE, bus_b.STALL, bus_b.RESTORE, bus_b.IN_SERVICE, bus_b.IE};
      chk("model_flags_b", 32'(act_f), 32'(exp_f));
      chk("model_saved_pc", 32'(bus_a.SAVED_PC), m_saved);
      chk("model_vaddr_a", 32'(bus_a.VECTOR_ADDR), m_va);
      chk("model_vaddr_b", 32'(bus_b.VECTOR_ADDR), m_vb);
   endtask

   task automatic step();
      @(posedge CLK);
      model_update();
      #1;
      check_model();
   endtask

   task automatic idle_in();
      t_rst = 0; t_int = 0; t_bnd = 0; t_set = 0; t_clr = 0; t_reti = 0; t_intv = 0;
   endtask

   task automatic wait_take(input string name);
      bit seen;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step();
         if (bus_a.TAKE) seen = 1;
      end
      chk(name, 32'(seen), 32'd1);
   endtask

   typedef struct {
      logic        rst, intr, bnd, set, clr, reti;
      logic [2:0]  intv;
      logic [15:0] pc;
      logic [4:0]  e_flags;   // intack, take, ie, in_service, restore
      logic [15:0] e_va;
      logic [15:0] e_pc;
   } vec_t;

   vec_t tbl[9];

   initial begin
      tbl[0] = '{1,0,0,0,0,0, 3'd0, 16'h0000, 5'b00000, 16'h0000, 16'h0000};
      tbl[1] = '{0,0,0,1,0,0, 3'd0, 16'h0000, 5'b00100, 16'h0000, 16'h0000};
      tbl[2] = '{0,1,1,0,0,0, 3'd5, 16'h0123, 5'b10000, 16'h0000, 16'h0123};
      tbl[3] = '{0,1,0,0,0,0, 3'd5, 16'h0000, 5'b10000, 16'h0000, 16'h0123};
      tbl[4] = '{0,1,0,0,0,0, 3'd5, 16'h0000, 5'b01000, 16'hFF14, 16'h0123};
      tbl[5] = '{0,1,0,0,0,0, 3'd0, 16'h0000, 5'b00010, 16'hFF14, 16'h0123};
      tbl[6] = '{0,1,1,0,0,0, 3'd0, 16'h0000, 5'b00010, 16'hFF14, 16'h0123};
      tbl[7] = '{0,1,1,0,0,1, 3'd0, 16'h0000, 5'b00101, 16'hFF14, 16'h0123};
      tbl[8] = '{0,1,1,0,0,0, 3'd0, 16'h0456, 5'b10000, 16'hFF14, 16'h0456};

      for (int i = 0; i < 9; i++) begin
         t_rst = tbl[i].rst; t_int = tbl[i].intr; t_bnd = tbl[i].bnd; t_set = tbl[i].set;
         t_clr = tbl[i].clr; t_reti = tbl[i].reti; t_intv = tbl[i].intv; t_pc = tbl[i].pc;
         step();
         chk($sformatf("tbl%0d_flags", i),
             32'({bus_a.INTACK, bus_a.TAKE, bus_a.IE, bus_a.IN_SERVICE, bus_a.RESTORE}), 32'(tbl[i].e_flags));
         chk($sformatf("tbl%0d_vaddr", i), 32'(bus_a.VECTOR_ADDR), 32'(tbl[i].e_va));
         chk($sformatf("tbl%0d_saved", i), 32'(bus_a.SAVED_PC), 32'(tbl[i].e_pc));
      end

      // reset held two cycles while INTACK is high
      idle_in(); t_rst = 1;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("rst_mid_ack", 32'({bus_a.INTACK, bus_a.TAKE, bus_a.STALL, bus_a.IE, bus_a.IN_SERVICE}), 32'd0);
         chk("rst_vaddr", 32'(bus_a.VECTOR_ADDR), 32'd0);
      end
      idle_in();
      step();
      chk("after_rst_take", 32'(bus_a.TAKE), 32'd0);

      // INT pending with IE=0 is never acknowledged
      begin
         int acks;
         acks = 0;
         t_int = 1; t_bnd = 1;
         for (int i = 0; i < 10; i++) begin
            step();
            if (bus_a.INTACK) acks++;
         end
         chk("no_ack_ie0", 32'(acks), 32'd0);
      end
      t_int = 0; t_set = 1; t_clr = 1;
      step();
      chk("set_clr_clear_wins", 32'(bus_a.IE), 32'd0);

      // wrap-around vector with INTV=7
      idle_in(); t_set = 1;
      step();
      idle_in(); t_int = 1; t_bnd = 1; t_intv = 3'd7; t_pc = 16'hBEEF;
      step();
      t_bnd = 0;
      wait_take("take_intv7");
      chk("vaddr_a_intv7", 32'(bus_a.VECTOR_ADDR), 32'h0000FF1C);
      chk("vaddr_b_wrap", 32'(bus_b.VECTOR_ADDR), 32'h00000028);
      idle_in();
      step();
      t_reti = 1;
      step();
      chk("reti_restore", 32'({bus_a.RESTORE, bus_a.IE}), 32'b11);

      // INT dropped during first ACK cycle with INTV=0
      idle_in(); t_int = 1; t_bnd = 1; t_intv = 3'd3;
      step();
      idle_in();
      wait_take("take_int_drop");
      chk("vaddr_a_drop", 32'(bus_a.VECTOR_ADDR), 32'h0000FF00);
      chk("vaddr_b_drop", 32'(bus_b.VECTOR_ADDR), 32'h0000FFF0);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         t_rst  = ($urandom_range(0, 299) == 0);
         t_int  = ($urandom_range(0, 3) != 0);
         t_bnd  = $urandom_range(0, 1) == 1;
         t_set  = ($urandom_range(0, 3) == 0);
         t_clr  = ($urandom_range(0, 9) == 0);
         t_reti = ($urandom_range(0, 5) == 0);
         t_intv = 3'($urandom_range(0, 7));
         t_pc   = 16'($urandom);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end
endmodule
